// File: rtl/keystream_serializer_if.sv
// rtl/keystream_serializer_if.sv - valid/ready bundle: state matrix in, byte stream out
interface keystream_serializer_if #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_WORDS = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_state [NUM_WORDS];
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_byte;
  logic                 out_first;
  logic                 out_last;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_byte, out_first, out_last
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_byte, out_first, out_last
  );
endinterface

// File: rtl/keystream_serializer.sv
// rtl/keystream_serializer.sv - holds one ChaCha20 state matrix and emits it little-endian, one byte per beat
module keystream_serializer #(
  parameter  int DATA_SIZE = 8,
  parameter  int NUM_WORDS = 16,
  localparam int NO_BYTES  = NUM_WORDS * 4
) (
  input  logic                  clk,
  input  logic                  rst,
  keystream_serializer_if.slave bus,
  output logic [31:0]           blk_count_o
);
  localparam int IDX_W = $clog2(NO_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_BYTES - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [31:0]      buf_q [NUM_WORDS];
  logic [31:0]      buf_d [NUM_WORDS];
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]      blk_count_q, blk_count_d;

  logic        out_valid;
  logic        beat;
  logic        last_beat;
  logic        accept;
  logic [31:0] cur_word;

  assign out_valid = (state_q == SEND);
  assign beat      = out_valid & bus.out_ready;
  assign last_beat = beat & (byte_idx_q == LAST_IDX);
  // Reload is allowed on the final beat so consecutive matrices stream without a bubble.
  assign bus.in_ready = (state_q == IDLE) | last_beat;
  assign accept       = bus.in_valid & bus.in_ready;

  assign cur_word      = buf_q[byte_idx_q[IDX_W-1:2]];
  assign bus.out_valid = out_valid;
  assign bus.out_byte  = out_valid ? cur_word[{byte_idx_q[1:0], 3'b000} +: DATA_SIZE] : '0;
  assign bus.out_first = out_valid & (byte_idx_q == '0);
  assign bus.out_last  = out_valid & (byte_idx_q == LAST_IDX);
  assign blk_count_o   = blk_count_q;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    byte_idx_d  = byte_idx_q;
    blk_count_d = blk_count_q;
    if (beat) begin
      byte_idx_d = byte_idx_q + IDX_W'(1);
      if (last_beat) begin
        blk_count_d = blk_count_q + 32'd1;
        byte_idx_d  = '0;
        state_d     = IDLE;
      end
    end
    if (accept) begin
      buf_d      = bus.in_state;
      byte_idx_d = '0;
      state_d    = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '{default: '0};
      byte_idx_q  <= '0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      byte_idx_q  <= byte_idx_d;
      blk_count_q <= blk_count_d;
    end
  end
endmodule

// File: tb/tb_keystream_serializer.sv
// tb/tb_keystream_serializer.sv - randomized bench with a byte-queue reference model
module tb_keystream_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] blk_count;

  always #5 clk = ~clk;

  keystream_serializer_if bus ();

  keystream_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .blk_count_o (blk_count)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  int          pos = 0;
  logic [31:0] exp_blk = '0;
  logic        last_acc = 1'b0;
  logic        stalled_prev = 1'b0;
  logic [7:0]  prev_byte = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: byte n of the matrix is n; mode 1: same ^0xFF; mode 2: random
  task automatic fill(input int mode);
    for (int w = 0; w < 16; w++) begin
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < 4; k++) begin
        int b;
        b = 4 * w + k;
        if (mode == 1) b = b ^ 255;
        if (mode == 2) b = int'($urandom_range(0, 255));
        v = v | (32'(b) << (8 * k));
      end
      bus.in_state[w] = v;
    end
  endtask

  task automatic step();
    logic        hs, acc, rst_now;
    logic [31:0] snap [16];
    @(negedge clk);
    rst_now = rst;
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("in_ready", bus.in_ready, (exp_q.size() == 0) || (bus.out_ready && pos == 63));
    check("blk_count", blk_count, exp_blk);
    if (exp_q.size() != 0) begin
      check("out_byte", bus.out_byte, exp_q[0]);
      check("out_first", bus.out_first, pos == 0);
      check("out_last", bus.out_last, pos == 63);
      if (stalled_prev) check("stall_hold", bus.out_byte, prev_byte);
    end else begin
      check("idle_byte", bus.out_byte, 0);
      check("idle_flags", {bus.out_first, bus.out_last}, 0);
    end
    hs  = (exp_q.size() != 0) && bus.out_ready;
    acc = bus.in_valid && ((exp_q.size() == 0) || (hs && pos == 63));
    stalled_prev = (exp_q.size() != 0) && !bus.out_ready;
    prev_byte    = bus.out_byte;
    for (int i = 0; i < 16; i++) snap[i] = bus.in_state[i];
    @(posedge clk);
    if (rst_now) begin
      exp_q.delete();
      pos          = 0;
      exp_blk      = '0;
      stalled_prev = 1'b0;
      last_acc     = 1'b0;
    end else begin
      if (hs) begin
        void'(exp_q.pop_front());
        pos++;
        if (pos == 64) begin
          pos = 0;
          exp_blk = exp_blk + 32'd1;
        end
      end
      if (acc)
        for (int w = 0; w < 16; w++)
          for (int k = 0; k < 4; k++)
            exp_q.push_back(8'((snap[w] >> (8 * k)) & 32'hFF));
      last_acc = acc;
    end
    #1;
  endtask

  task automatic send_wait(input bit rand_ready);
    int budget;
    budget = 400;
    bus.in_valid = 1'b1;
    do begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      budget--;
    end while (!last_acc && budget > 0);
    if (!last_acc) check("accept_timeout", 0, 1);
  endtask

  task automatic drain(input bit rand_ready);
    int budget;
    budget = 600;
    while (exp_q.size() != 0 && budget > 0) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      budget--;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    bus.out_ready = 1'b1;
    step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    fill(0);
    step();
    step();
    rst = 1'b0;

    // T1: idle after reset
    repeat (5) step();

    // T2: counting matrix at full rate
    bus.out_ready = 1'b1;
    fill(0);
    send_wait(0);
    bus.in_valid = 1'b0;
    drain(0);

    // T3: same matrix under random backpressure
    fill(0);
    send_wait(1);
    bus.in_valid = 1'b0;
    drain(1);

    // T4: two matrices back to back, in_valid held
    bus.out_ready = 1'b1;
    fill(0);
    send_wait(0);
    fill(1);
    send_wait(0);
    bus.in_valid = 1'b0;
    drain(0);

    // T5: reset on byte 20
    fill(2);
    send_wait(0);
    bus.in_valid = 1'b0;
    for (int n = 0; n < 100 && pos != 20; n++) step();
    check("t5_reached_20", pos, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("t5_blk_cleared", blk_count, 32'h0);
    fill(0);
    send_wait(0);
    bus.in_valid = 1'b0;
    drain(0);

    // T6: blk_count wrap
    force dut.blk_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.blk_count_q;
    exp_blk = 32'hFFFF_FFFF;
    step();
    fill(2);
    send_wait(0);
    bus.in_valid = 1'b0;
    drain(0);
    check("t6_wrap", blk_count, 32'h0);

    // random matrices with random backpressure, reloaded as soon as accepted
    for (int m = 0; m < 4; m++) begin
      fill(2);
      send_wait(1);
    end
    bus.in_valid = 1'b0;
    drain(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
